bcd_seg7_scan: RTL and testbench
================================

// Module: bcd_seg7_scan
// PURPOSE
//  Drives a 4-digit multiplexed 7-segment display from the units/tens/hundreds
//  BCD bus of the 8-bit binary-to-BCD converter (value 0..255).
//  - Double-buffers the BCD value so the display never tears mid-frame.
//  - Scans digits with a prescaled refresh tick.
//  - Decodes BCD to segments and optionally blanks leading zeros.
// PARAMETERS
//  PRESCALE    100000  clk cycles per digit slot (>=1; 100 MHz -> 1 kHz/digit)
//  ACTIVE_LOW  1       1: an/seg/dp active-low (common anode); 0: active-high
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  reset       in   1  asynchronous, active-high reset
//  units       in   4  BCD units digit from converter
//  tens        in   4  BCD tens digit from converter
//  hundreds    in   2  BCD hundreds digit (0..2), zero-extended internally
//  load        in   1  1-cycle strobe: capture units/tens/hundreds into pending buffer
//  blank_lz    in   1  1: blank leading zeros on digits 2 and 1
//  seg         out  7  segments {g,f,e,d,c,b,a}, registered
//  an          out  4  digit enables, an[0]=units .. an[3]=unused digit, registered
//  dp          out  1  decimal point, always inactive
//  frame_done  out  1  1-cycle pulse in the cycle digit 0 first becomes visible
// BEHAVIOUR
//  Reset (async, immediate, incl. mid-scan):
//  - prescaler=0, dig_sel=3, pending/display regs=0, pend_valid=0.
//  - an, seg, dp all inactive (1111 / 1111111 / 1 when ACTIVE_LOW); frame_done=0.
//  Prescaler:
//  - Counts 0..PRESCALE-1, wraps to 0.
//  - tick=1 in the cycle count==PRESCALE-1.
//  Scan FSM (dig_sel 2b):
//  - On tick: 3->0->1->2->3; no change without tick.
//  - an/seg registered on the tick edge: new digit visible the cycle after tick.
//  - Exactly one an bit active at any time after the first tick.
//  Buffering:
//  - load=1 copies inputs to pending and sets pend_valid; a later load overwrites.
//  - Frame boundary = tick with dig_sel==3 (incl. first tick after reset):
//    if pend_valid, display<=pending and pend_valid<=0.
//  - load coincident with frame boundary: current inputs go straight to display
//    and pend_valid stays 0.
//  - load at any other time: display unchanged until next frame boundary.
//  Digit source:
//  - d0=units, d1=tens, d2={2'b00,hundreds}; d3 always blank (no segments).
//  Decode (active-high form {g..a}; inverted when ACTIVE_LOW):
//  - 0=0111111  1=0000110  2=1011011  3=1001111  4=1100110
//  - 5=1101101  6=1111101  7=0000111  8=1111111  9=1101111
//  - 10..15 (invalid BCD) = dash 1000000.
//  Blanking (evaluated on display regs, blank_lz sampled at the tick):
//  - blank_lz=1 and hundreds==0: d2 blank.
//  - additionally tens==0: d1 blank.
//  - d0 never blanked; blank_lz=0 shows all of d0..d2.
//  Outputs:
//  - Blank digit: an still scans, seg all inactive.
//  - frame_done registered with the tick edge that enters dig_sel 0.
// TESTING (PRESCALE=4, ACTIVE_LOW=1)
//  1. Reset released -> an=1111, seg=1111111, frame_done=0 for 4 cycles;
//     cycle after first tick: an=1110, frame_done=1 for 1 cycle.
//  2. load 125 (u=5,t=2,h=1) before first tick -> slots show an=1110/seg=0010010,
//     1101/0100100, 1011/1111001, 0111/1111111.
//  3. load 7 with blank_lz=1 -> d1,d2 seg=1111111;
//     same with blank_lz=0 -> d1,d2 seg=1000000.
//  4. load 99 while dig_sel==1 -> d1,d2 keep old value; new digits appear
//     from next frame_done.
//  5. load with units=4'hC -> d0 seg=0111111 (dash).
//  6. reset pulsed while dig_sel==2 -> same cycle an=1111, seg=1111111;
//     after release, test 1 sequence repeats.

Source files
------------

// File: rtl/bcd_seg7_scan.sv
// rtl/bcd_seg7_scan.sv - 4-digit multiplexed 7-segment scanner for a 0..255 BCD value
// Double-buffered display value, prescaled digit scan, BCD decode with leading-zero blanking.
module bcd_seg7_scan #(
    parameter int PRESCALE   = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [1:0] hundreds,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_done
);

    localparam int             CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [6:0]     SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]     AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_dig_sel;
    logic [3:0]    r_pend_u, r_pend_t, r_disp_u, r_disp_t;
    logic [1:0]    r_pend_h, r_disp_h;
    logic          r_pend_valid;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_frame_done;

    logic          w_tick, w_boundary, w_blank;
    logic [1:0]    w_next_sel;
    logic [3:0]    w_disp_u, w_disp_t, w_digit;
    logic [1:0]    w_disp_h;
    logic [6:0]    w_seg_on, w_seg_out;
    logic [3:0]    w_an_on, w_an_out;

    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign w_tick     = (r_cnt == CNT_MAX);
    assign w_boundary = w_tick && (r_dig_sel == 2'd3);
    assign w_next_sel = r_dig_sel + 2'd1;

    // Value being latched into the display this cycle; digit 0 of a new frame must use it.
    always_comb begin
        w_disp_u = r_disp_u;
        w_disp_t = r_disp_t;
        w_disp_h = r_disp_h;
        if (w_boundary) begin
            if (load) begin
                w_disp_u = units;
                w_disp_t = tens;
                w_disp_h = hundreds;
            end else if (r_pend_valid) begin
                w_disp_u = r_pend_u;
                w_disp_t = r_pend_t;
                w_disp_h = r_pend_h;
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (w_next_sel)
            2'd0: w_digit = w_disp_u;
            2'd1: begin
                w_digit = w_disp_t;
                w_blank = blank_lz && (w_disp_h == 2'd0) && (w_disp_t == 4'd0);
            end
            2'd2: begin
                w_digit = {2'b00, w_disp_h};
                w_blank = blank_lz && (w_disp_h == 2'd0);
            end
            default: w_blank = 1'b1;
        endcase
    end

    assign w_seg_on  = w_blank ? 7'h00 : seg7_decode(w_digit);
    assign w_seg_out = ACTIVE_LOW ? ~w_seg_on : w_seg_on;
    assign w_an_on   = 4'b0001 << w_next_sel;
    assign w_an_out  = ACTIVE_LOW ? ~w_an_on : w_an_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_dig_sel    <= 2'd3;
            r_pend_u     <= 4'd0;
            r_pend_t     <= 4'd0;
            r_pend_h     <= 2'd0;
            r_pend_valid <= 1'b0;
            r_disp_u     <= 4'd0;
            r_disp_t     <= 4'd0;
            r_disp_h     <= 2'd0;
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CW'(1);
            r_frame_done <= 1'b0;
            if (w_tick) begin
                r_dig_sel    <= w_next_sel;
                r_seg        <= w_seg_out;
                r_an         <= w_an_out;
                r_frame_done <= (w_next_sel == 2'd0);
            end
            if (w_boundary) begin
                r_disp_u     <= w_disp_u;
                r_disp_t     <= w_disp_t;
                r_disp_h     <= w_disp_h;
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_u     <= units;
                r_pend_t     <= tens;
                r_pend_h     <= hundreds;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign dp         = ACTIVE_LOW;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb/tb_bcd_seg7_scan.sv - scoreboard bench for bcd_seg7_scan (PRESCALE=4, active-low)
module tb_bcd_seg7_scan;

    typedef struct {
        int         ld_edge;
        logic [3:0] u;
        logic [3:0] tn;
        logic [1:0] h;
    } load_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] units = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [1:0] hundreds = 2'd0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       frame_done;

    int    errors = 0;
    int    checks = 0;
    load_t loads[$];
    exp_t  exp_q[$];
    logic [3:0] prev_an = 4'hF;
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    bcd_seg7_scan #(.PRESCALE(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .units(units), .tens(tens), .hundreds(hundreds),
        .load(load), .blank_lz(blank_lz), .seg(seg), .an(an), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Slot n starts at edge 4(n+1) and shows digit n%4; frame f latches the newest load
    // sampled at or before its boundary edge 16f+4.
    function automatic exp_t expect_at(input int t, input logic bl);
        exp_t       r;
        int         n, dig, bnd;
        logic [3:0] u, tn, d;
        logic [1:0] h;
        bit         blank;
        n = t / 4 - 1;
        dig = n % 4;
        bnd = 16 * (n / 4) + 4;
        u = 4'd0; tn = 4'd0; h = 2'd0;
        foreach (loads[i]) begin
            if (loads[i].ld_edge <= bnd) begin
                u = loads[i].u; tn = loads[i].tn; h = loads[i].h;
            end
        end
        d = 4'd0;
        blank = 1'b0;
        case (dig)
            0: d = u;
            1: begin d = tn; blank = bl && (h == 0) && (tn == 0); end
            2: begin d = {2'b00, h}; blank = bl && (h == 0); end
            default: blank = 1'b1;
        endcase
        r.an  = ~(4'b0001 << dig);
        r.seg = blank ? 7'h7F : ~seg_tab[d];
        r.fd  = (dig == 0);
        return r;
    endfunction

    task automatic drive(input int t);
        bit do_load;
        int v;
        load = 1'b0;
        units = 4'($urandom);
        tens = 4'($urandom);
        hundreds = 2'($urandom);
        do_load = 1'b0;
        if (t < 80) blank_lz = (t >= 17 && t <= 35);
        else if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
        if (t == 1) begin units = 4'd5; tens = 4'd2; hundreds = 2'd1; do_load = 1'b1; end
        else if (t == 20) begin units = 4'd7; tens = 4'd0; hundreds = 2'd0; do_load = 1'b1; end
        else if (t == 42) begin units = 4'd9; tens = 4'd9; hundreds = 2'd0; do_load = 1'b1; end
        else if (t == 60) begin units = 4'hC; tens = 4'd0; hundreds = 2'd0; do_load = 1'b1; end
        else if (t >= 80 && $urandom_range(0, 7) == 0) begin
            do_load = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                units = 4'($urandom); tens = 4'($urandom); hundreds = 2'($urandom);
            end else begin
                case ($urandom_range(0, 2))
                    0: v = $urandom_range(0, 9);
                    1: v = $urandom_range(0, 99);
                    default: v = $urandom_range(0, 255);
                endcase
                units = 4'(v % 10); tens = 4'((v / 10) % 10); hundreds = 2'(v / 100);
            end
        end
        if (do_load) begin
            load = 1'b1;
            loads.push_back('{t, units, tens, hundreds});
        end
        if (t % 4 == 0) exp_q.push_back(expect_at(t, blank_lz));
    endtask

    task automatic run_phase(input int nedges);
        loads.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < nedges; e++) begin
            if (e < 4) begin
                chk("pre_tick_an", 32'(an), 32'hF);
                chk("pre_tick_seg", 32'(seg), 32'h7F);
                chk("pre_tick_fd", 32'(frame_done), 32'h0);
            end
            drive(e + 1);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_an <= 4'hF;
        end else begin
            chk("dp", 32'(dp), 32'h1);
            if (an != prev_an) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_scan: got an=%b with no expectation queued", an);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("scan_an", 32'(an), 32'(x.an));
                    chk("scan_seg", 32'(seg), 32'(x.seg));
                    chk("scan_fd", 32'(frame_done), 32'(x.fd));
                end
                prev_an <= an;
            end else begin
                chk("fd_idle", 32'(frame_done), 32'h0);
            end
        end
    end

    initial begin
        #12;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_fd", 32'(frame_done), 32'h0);
        chk("reset_dp", 32'(dp), 32'h1);
        run_phase(172);
        // Edge 172 entered digit 2; reset lands mid-slot and must clear outputs at once.
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_an", 32'(an), 32'hF);
        chk("async_reset_seg", 32'(seg), 32'h7F);
        chk("async_reset_fd", 32'(frame_done), 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        run_phase(200);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
